// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a shared synchronous-read memory port, round-robin with optional locked bursts.
// Lock bursts (LOCK0/LOCK1 states, lcnt) are built only when MEM_ARB_LOCK_EN is defined.
module mem_arbiter #(
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [1:0]  req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic        req0_lock,
   output logic        req0_rvalid,
   output logic [31:0] req0_rdata,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [1:0]  req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic        req1_lock,
   output logic        req1_rvalid,
   output logic [31:0] req1_rdata,

   output logic [31:0] mem_rd_addr,
   input  logic [31:0] mem_rd_data,
   output logic [1:0]  mem_wr_en,
   output logic [31:0] mem_wr_addr,
   output logic [31:0] mem_wr_data
);

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned WEW    = 2;
   localparam int unsigned LCNT_W = 8;

   logic          ptr;
   logic          gnt0;
   logic          gnt1;
   logic          hold0;
   logic          hold1;
   logic          acc;
   logic [WEW-1:0] sel_we;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_wdata;

`ifdef MEM_ARB_LOCK_EN
   typedef enum logic [1:0] {
      ST_OPEN  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [LCNT_W-1:0]   lcnt;
   logic [LCNT_W-1:0]   lcnt_nxt;
   logic [LCNT_W-1:0]   lcnt_inc;
   logic                sel_lock;

   // A locked owner keeps the grant only while it is actually requesting
   assign hold0    = (state == ST_LOCK0) && req0_valid;
   assign hold1    = (state == ST_LOCK1) && req1_valid;
   assign sel_lock = gnt1 ? req1_lock : req0_lock;
   assign lcnt_inc = lcnt + LCNT_W'(1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OPEN;
         lcnt  <= '0;
      end else begin
         state <= state_nxt;
         lcnt  <= lcnt_nxt;
      end
   end

   // Next-state: enter, extend or release a locked burst
   always_comb begin
      state_nxt = state;
      lcnt_nxt  = lcnt;
      if (hold0 || hold1) begin
         if (!sel_lock || (lcnt_inc == LCNT_W'(MAX_LOCK))) begin
            state_nxt = ST_OPEN;
            lcnt_nxt  = '0;
         end else begin
            lcnt_nxt  = lcnt_inc;
         end
      end else if (acc && sel_lock && (MAX_LOCK > 1)) begin
         state_nxt = gnt1 ? ST_LOCK1 : ST_LOCK0;
         lcnt_nxt  = LCNT_W'(1);
      end else begin
         state_nxt = ST_OPEN;
         lcnt_nxt  = '0;
      end
   end
`else
   logic unused_lock;

   assign hold0       = 1'b0;
   assign hold1       = 1'b0;
   assign unused_lock = req0_lock ^ req1_lock;
`endif

   // Grant: locked owner first, otherwise sole requester or round-robin pointer
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst_n) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end else if (hold0) begin
         gnt0 = 1'b1;
      end else if (hold1) begin
         gnt1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
         gnt0 = !ptr;
         gnt1 = ptr;
      end else begin
         gnt0 = req0_valid;
         gnt1 = req1_valid;
      end
   end

   assign acc        = gnt0 | gnt1;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign sel_we    = gnt1 ? req1_we    : req0_we;
   assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
   assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;

   // Memory port is idle (all zero) unless a transfer is accepted
   always_comb begin
      mem_rd_addr = '0;
      mem_wr_en   = '0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      if (acc) begin
         if (sel_we == 2'b00) begin
            mem_rd_addr = sel_addr;
         end else begin
            mem_wr_en   = sel_we;
            mem_wr_addr = sel_addr;
            mem_wr_data = sel_wdata;
         end
      end
   end

   // Pointer and read-response tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= 1'b0;
         req0_rvalid <= 1'b0;
         req1_rvalid <= 1'b0;
      end else begin
         if (acc) begin
            ptr <= gnt0;
         end
         req0_rvalid <= gnt0 && (req0_we == 2'b00);
         req1_rvalid <= gnt1 && (req1_we == 2'b00);
      end
   end

   // Memory data arrives one cycle after the address; steer it to the owner
   assign req0_rdata = req0_rvalid ? mem_rd_data : DW'(0);
   assign req1_rdata = req1_rvalid ? mem_rd_data : DW'(0);

endmodule
